// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared widths, types and byte-mask helper for the store buffer
// Contents: bus/ROB widths, commit feedback pack, buffer entry struct,
//           access-size encodings and the byte-lane mask function.
package store_buffer_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int BUS_DATA_WIDTH = 32;
    localparam int SIZE_WIDTH     = 2;
    localparam int ROB_ID_WIDTH   = 6;

    localparam logic [SIZE_WIDTH-1:0] SIZE_BYTE = 2'b00;
    localparam logic [SIZE_WIDTH-1:0] SIZE_HALF = 2'b01;
    localparam logic [SIZE_WIDTH-1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic                    enable;
        logic                    flush;
        logic [ROB_ID_WIDTH-1:0] committed_rob_id;
        logic                    committed_rob_id_valid;
    } commit_feedback_pack_t;

    typedef struct packed {
        logic [ROB_ID_WIDTH-1:0]   rob_id;
        logic [ADDR_WIDTH-1:0]     addr;
        logic [SIZE_WIDTH-1:0]     size;
        logic [BUS_DATA_WIDTH-1:0] data;
    } store_buffer_entry_t;

    // Byte lanes of the bus word touched by an access; the reserved size
    // encoding is treated as a full word.
    function automatic logic [3:0] byte_mask(input logic [SIZE_WIDTH-1:0] size,
                                             input logic [1:0]            offset);
        logic [3:0] base;
        case (size)
            SIZE_BYTE: base = 4'b0001;
            SIZE_HALF: base = 4'b0011;
            default:   base = 4'b1111;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/store_buffer_forward.sv
// rtl/store_buffer_forward.sv - merges buffered store bytes onto a bus read word
// Ports: entries (buffer storage), head/tail (wrap-bit pointers bounding the
//        valid entries), read_word_addr (load address bits [ADDR_WIDTH-1:2]),
//        bus_data (raw read word), merged (word with store bytes applied).
module store_buffer_forward
    import store_buffer_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  store_buffer_entry_t [SIZE-1:0]     entries,
    input  logic [$clog2(SIZE):0]              head,
    input  logic [$clog2(SIZE):0]              tail,
    input  logic [ADDR_WIDTH-3:0]              read_word_addr,
    input  logic [BUS_DATA_WIDTH-1:0]          bus_data,
    output logic [BUS_DATA_WIDTH-1:0]          merged
);

    localparam int IDX_W = $clog2(SIZE);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]          count;
    logic [IDX_W-1:0]          idx;
    logic [3:0]                mask;
    logic [BUS_DATA_WIDTH-1:0] shifted;

    assign count = tail - head;

    // Walk from the oldest entry (head) to the youngest so later stores
    // overwrite earlier ones on overlapping bytes.
    always_comb begin
        merged  = bus_data;
        idx     = '0;
        mask    = '0;
        shifted = '0;
        for (int i = 0; i < SIZE; i++) begin
            idx     = head[IDX_W-1:0] + IDX_W'(i);
            mask    = byte_mask(entries[idx].size, entries[idx].addr[1:0]);
            shifted = entries[idx].data << {entries[idx].addr[1:0], 3'b000};
            if ((PTR_W'(i) < count) &&
                (entries[idx].addr[ADDR_WIDTH-1:2] == read_word_addr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask[b]) begin
                        merged[8*b +: 8] = shifted[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order speculative store buffer with drain and load forwarding
// Ports: clk/rst; exlsu_stbuf_* push and load requests from the LSU;
//        stbuf_exlsu_* full flag and load results; stbuf_bus_* / bus_stbuf_*
//        bus read and write channels; commit_feedback_pack commit/flush info.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int STORE_BUFFER_SIZE = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ROB_ID_WIDTH-1:0]   exlsu_stbuf_rob_id,
    input  logic [ADDR_WIDTH-1:0]     exlsu_stbuf_write_addr,
    input  logic [SIZE_WIDTH-1:0]     exlsu_stbuf_write_size,
    input  logic [BUS_DATA_WIDTH-1:0] exlsu_stbuf_write_data,
    input  logic                      exlsu_stbuf_push,
    output logic                      stbuf_exlsu_full,
    input  logic [ADDR_WIDTH-1:0]     exlsu_stbuf_read_addr,
    input  logic [SIZE_WIDTH-1:0]     exlsu_stbuf_read_size,
    input  logic                      exlsu_stbuf_read_req,
    output logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data,
    output logic [BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data_feedback,
    output logic                      stbuf_exlsu_bus_ready,
    output logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr,
    output logic                      stbuf_bus_read_req,
    input  logic [BUS_DATA_WIDTH-1:0] bus_stbuf_read_data,
    input  logic                      bus_stbuf_read_ack,
    output logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr,
    output logic [BUS_DATA_WIDTH-1:0] stbuf_bus_write_data,
    output logic [SIZE_WIDTH-1:0]     stbuf_bus_write_size,
    output logic                      stbuf_bus_write_req,
    input  logic                      bus_stbuf_write_ack,
    input  commit_feedback_pack_t     commit_feedback_pack
);

    localparam int IDX_W = $clog2(STORE_BUFFER_SIZE);
    localparam int PTR_W = IDX_W + 1;

    store_buffer_entry_t [STORE_BUFFER_SIZE-1:0] entries;
    store_buffer_entry_t                         head_entry;
    logic [PTR_W-1:0] head, commit_ptr, tail, commit_ptr_next;
    logic             commit_fire, flush_fire, push_fire, pop_fire;
    logic [SIZE_WIDTH+1:0] read_bits_unused;

    // Load size does not narrow the merge: the whole word is returned and
    // the LSU extracts the lanes it needs.
    assign read_bits_unused = {exlsu_stbuf_read_size, exlsu_stbuf_read_addr[1:0]};

    assign head_entry       = entries[head[IDX_W-1:0]];
    assign stbuf_exlsu_full = (tail - head) == PTR_W'(STORE_BUFFER_SIZE);

    // Drain channel: outputs are forced to zero when idle so stale storage
    // never appears on the bus.
    assign stbuf_bus_write_req  = (head != commit_ptr);
    assign stbuf_bus_write_addr = stbuf_bus_write_req ? head_entry.addr : '0;
    assign stbuf_bus_write_size = stbuf_bus_write_req ? head_entry.size : '0;
    assign stbuf_bus_write_data = stbuf_bus_write_req ?
        (head_entry.data << {head_entry.addr[1:0], 3'b000}) : '0;

    assign commit_fire = commit_feedback_pack.enable &&
                         commit_feedback_pack.committed_rob_id_valid &&
                         (commit_ptr != tail) &&
                         (entries[commit_ptr[IDX_W-1:0]].rob_id ==
                          commit_feedback_pack.committed_rob_id);
    assign commit_ptr_next = commit_ptr + PTR_W'(commit_fire);
    assign flush_fire      = commit_feedback_pack.enable && commit_feedback_pack.flush;
    assign push_fire       = exlsu_stbuf_push && !stbuf_exlsu_full && !flush_fire;
    assign pop_fire        = stbuf_bus_write_req && bus_stbuf_write_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            commit_ptr <= '0;
            tail       <= '0;
        end else begin
            if (pop_fire) begin
                head <= head + PTR_W'(1);
            end
            commit_ptr <= commit_ptr_next;
            if (flush_fire) begin
                tail <= commit_ptr_next;
            end else if (push_fire) begin
                tail <= tail + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            entries[tail[IDX_W-1:0]] <= '{rob_id: exlsu_stbuf_rob_id,
                                          addr:   exlsu_stbuf_write_addr,
                                          size:   exlsu_stbuf_write_size,
                                          data:   exlsu_stbuf_write_data};
        end
    end

    assign stbuf_bus_read_addr   = {exlsu_stbuf_read_addr[ADDR_WIDTH-1:2], 2'b00};
    assign stbuf_bus_read_req    = exlsu_stbuf_read_req;
    assign stbuf_exlsu_bus_ready = bus_stbuf_read_ack;
    assign stbuf_exlsu_bus_data  = bus_stbuf_read_data;

    store_buffer_forward #(
        .SIZE (STORE_BUFFER_SIZE)
    ) u_forward (
        .entries        (entries),
        .head           (head),
        .tail           (tail),
        .read_word_addr (exlsu_stbuf_read_addr[ADDR_WIDTH-1:2]),
        .bus_data       (bus_stbuf_read_data),
        .merged         (stbuf_exlsu_bus_data_feedback)
    );

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic                      clk;
    logic                      rst;
    logic [ROB_ID_WIDTH-1:0]   rob_id;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [SIZE_WIDTH-1:0]     w_size;
    logic [BUS_DATA_WIDTH-1:0] w_data;
    logic                      push;
    logic                      full;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [SIZE_WIDTH-1:0]     r_size;
    logic                      r_req;
    logic [BUS_DATA_WIDTH-1:0] raw_data;
    logic [BUS_DATA_WIDTH-1:0] fb_data;
    logic                      ld_ready;
    logic [ADDR_WIDTH-1:0]     bus_r_addr;
    logic                      bus_r_req;
    logic [BUS_DATA_WIDTH-1:0] bus_r_data;
    logic                      bus_r_ack;
    logic [ADDR_WIDTH-1:0]     bus_w_addr;
    logic [BUS_DATA_WIDTH-1:0] bus_w_data;
    logic [SIZE_WIDTH-1:0]     bus_w_size;
    logic                      bus_w_req;
    logic                      bus_w_ack;
    commit_feedback_pack_t     cfp;

    int checks = 0;
    int errors = 0;

    store_buffer #(.STORE_BUFFER_SIZE(16)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .exlsu_stbuf_rob_id            (rob_id),
        .exlsu_stbuf_write_addr        (w_addr),
        .exlsu_stbuf_write_size        (w_size),
        .exlsu_stbuf_write_data        (w_data),
        .exlsu_stbuf_push              (push),
        .stbuf_exlsu_full              (full),
        .exlsu_stbuf_read_addr         (r_addr),
        .exlsu_stbuf_read_size         (r_size),
        .exlsu_stbuf_read_req          (r_req),
        .stbuf_exlsu_bus_data          (raw_data),
        .stbuf_exlsu_bus_data_feedback (fb_data),
        .stbuf_exlsu_bus_ready         (ld_ready),
        .stbuf_bus_read_addr           (bus_r_addr),
        .stbuf_bus_read_req            (bus_r_req),
        .bus_stbuf_read_data           (bus_r_data),
        .bus_stbuf_read_ack            (bus_r_ack),
        .stbuf_bus_write_addr          (bus_w_addr),
        .stbuf_bus_write_data          (bus_w_data),
        .stbuf_bus_write_size          (bus_w_size),
        .stbuf_bus_write_req           (bus_w_req),
        .bus_stbuf_write_ack           (bus_w_ack),
        .commit_feedback_pack          (cfp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_store(input logic [ROB_ID_WIDTH-1:0] id, input logic [31:0] addr,
                              input logic [1:0] size, input logic [31:0] data);
        rob_id = id; w_addr = addr; w_size = size; w_data = data; push = 1'b1;
        tick();
        push = 1'b0;
    endtask

    task automatic commit(input logic [ROB_ID_WIDTH-1:0] id);
        cfp.enable = 1'b1; cfp.committed_rob_id_valid = 1'b1; cfp.committed_rob_id = id;
        tick();
        cfp = '0;
    endtask

    task automatic flush();
        cfp.enable = 1'b1; cfp.flush = 1'b1;
        tick();
        cfp = '0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] bus_word);
        r_addr = addr; r_size = SIZE_WORD; r_req = 1'b1;
        bus_r_data = bus_word; bus_r_ack = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b1; rob_id = '0; w_addr = '0; w_size = '0; w_data = '0; push = 1'b0;
        r_addr = '0; r_size = '0; r_req = 1'b0; bus_r_data = 32'h12345678; bus_r_ack = 1'b0;
        bus_w_ack = 1'b0; cfp = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst_full",     32'(full),      32'd0);
        check("rst_wreq",     32'(bus_w_req), 32'd0);
        check("rst_waddr",    bus_w_addr,     32'd0);
        check("rst_wdata",    bus_w_data,     32'd0);
        check("rst_wsize",    32'(bus_w_size), 32'd0);
        check("rst_ready",    32'(ld_ready),  32'd0);
        check("rst_feedback", fb_data,        32'h12345678);
        check("rst_raw",      raw_data,       32'h12345678);

        // push sh then commit, drain
        push_store(6'd7, 32'haaccbeef, SIZE_HALF, 32'hdeadbeef);
        check("spec_no_wreq", 32'(bus_w_req), 32'd0);
        commit(6'd7);
        check("commit_wreq",  32'(bus_w_req), 32'd1);
        check("commit_waddr", bus_w_addr,     32'haaccbeef);
        check("commit_wsize", 32'(bus_w_size), 32'd1);
        check("commit_wdata", bus_w_data,     32'hef000000);
        bus_w_ack = 1'b1; tick(); bus_w_ack = 1'b0;
        check("ack_empty",    32'(bus_w_req), 32'd0);

        // youngest wins, wrong-id commit, flush
        push_store(6'd3, 32'h200, SIZE_WORD, 32'haaaa0000);
        push_store(6'd4, 32'h200, SIZE_WORD, 32'h5555ffff);
        load(32'h200, 32'h0);
        check("youngest_fb",  fb_data,          32'h5555ffff);
        check("ld_ready",     32'(ld_ready),    32'd1);
        check("ld_rreq",      32'(bus_r_req),   32'd1);
        commit(6'd9);
        check("wrong_id_wreq", 32'(bus_w_req),  32'd0);
        flush();
        load(32'h200, 32'hcafef00d);
        check("flushed_fb",   fb_data,          32'hcafef00d);

        // byte/half forwarding
        push_store(6'd1, 32'h100, SIZE_BYTE, 32'h11);
        push_store(6'd2, 32'h102, SIZE_HALF, 32'h2233);
        load(32'h100, 32'hdace1557);
        check("fwd_fb",       fb_data,          32'h22331511);
        check("fwd_raw",      raw_data,         32'hdace1557);
        load(32'h103, 32'hdace1557);
        check("fwd_raddr",    bus_r_addr,       32'h100);
        check("fwd_fb_unal",  fb_data,          32'h22331511);
        flush();

        // commit one, flush with same-cycle push
        push_store(6'd1, 32'h10, SIZE_WORD, 32'h1);
        push_store(6'd2, 32'h14, SIZE_WORD, 32'h2);
        push_store(6'd3, 32'h18, SIZE_WORD, 32'h3);
        commit(6'd1);
        cfp.enable = 1'b1; cfp.flush = 1'b1;
        rob_id = 6'd4; w_addr = 32'h1c; w_size = SIZE_WORD; w_data = 32'h4; push = 1'b1;
        tick();
        cfp = '0; push = 1'b0;
        check("flush_wreq",   32'(bus_w_req),   32'd1);
        check("flush_waddr",  bus_w_addr,       32'h10);
        check("flush_wdata",  bus_w_data,       32'h1);
        load(32'h10, 32'h0);
        check("flush_keep_c", fb_data,          32'h1);
        load(32'h14, 32'hffffffff);
        check("flush_drop_2", fb_data,          32'hffffffff);
        load(32'h1c, 32'hffffffff);
        check("flush_drop_4", fb_data,          32'hffffffff);
        commit(6'd2);
        check("post_flush_waddr", bus_w_addr,   32'h10);
        bus_w_ack = 1'b1; tick(); bus_w_ack = 1'b0;
        check("flush_drained", 32'(bus_w_req),  32'd0);

        // full and wrap-around
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 16; k++)
                push_store(ROB_ID_WIDTH'(k), 32'h300 + 32'(4 * k), SIZE_WORD,
                           32'h10000000 + 32'(rep * 256 + k));
            check("full_16", 32'(full), 32'd1);
            push_store(6'd63, 32'h400, SIZE_WORD, 32'h99);
            load(32'h400, 32'h0);
            check("push_refused", fb_data, 32'h0);
            load(32'h33c, 32'h0);
            check("last_visible", fb_data, 32'h10000000 + 32'(rep * 256 + 15));
            commit(6'd0);
            check("full_after_commit", 32'(full), 32'd1);
            for (int k = 1; k <= 16; k++) begin
                check("wrap_waddr", bus_w_addr, 32'h300 + 32'(4 * (k - 1)));
                check("wrap_wdata", bus_w_data, 32'h10000000 + 32'(rep * 256 + k - 1));
                bus_w_ack = 1'b1;
                if (k < 16) begin
                    cfp.enable = 1'b1; cfp.committed_rob_id_valid = 1'b1;
                    cfp.committed_rob_id = ROB_ID_WIDTH'(k);
                end
                tick();
                bus_w_ack = 1'b0; cfp = '0;
                if (k == 1) check("full_after_pop", 32'(full), 32'd0);
            end
            check("wrap_drained", 32'(bus_w_req), 32'd0);
        end

        // reset during outstanding write
        push_store(6'd5, 32'h40, SIZE_WORD, 32'h55);
        commit(6'd5);
        check("pre_rst_wreq", 32'(bus_w_req), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_wreq_lost", 32'(bus_w_req), 32'd0);
        check("rst_waddr_0",   bus_w_addr,     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
